// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: raster timing bundle from the sync generator to its consumers
interface vga_sync_gen_if;
    logic       p_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       frame_end;
    modport master (output p_tick, pixel_x, pixel_y, hsync, vsync, video_on, frame_end);
    modport slave  (input  p_tick, pixel_x, pixel_y, hsync, vsync, video_on, frame_end);
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running VGA raster timing with pixel enable, counters, syncs and frame strobe
module vga_sync_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic           clk,
    input  logic           reset,
    vga_sync_gen_if.master vga
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS = 10'(V_DISPLAY);
    localparam logic [9:0] HS_LO = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_HI = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_LO = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_HI = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    logic [DW-1:0] div;
    logic [9:0]    x, y, x_nxt, y_nxt;
    logic          hs, vs, tick, h_end;
    // >= rather than == so an upset counter value still wraps on the next advance
    always_comb begin
        tick  = div == DIV_MAX;
        h_end = x >= H_MAX;
        x_nxt = h_end ? '0 : x + 10'd1;
        y_nxt = h_end ? (y >= V_MAX ? '0 : y + 10'd1) : y;
    end
    // syncs are computed from next-state counters so they stay aligned with pixel_x/pixel_y
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div <= '0;
            x   <= '0;
            y   <= '0;
            hs  <= 1'b1;
            vs  <= 1'b1;
        end else begin
            div <= tick ? '0 : div + DW'(1);
            if (tick) begin
                x  <= x_nxt;
                y  <= y_nxt;
                hs <= !(x_nxt >= HS_LO && x_nxt <= HS_HI);
                vs <= !(y_nxt >= VS_LO && y_nxt <= VS_HI);
            end
        end
    end
    assign vga.p_tick    = tick;
    assign vga.pixel_x   = x;
    assign vga.pixel_y   = y;
    assign vga.hsync     = hs;
    assign vga.vsync     = vs;
    assign vga.video_on  = x < H_VIS && y < V_VIS;
    assign vga.frame_end = tick && x == H_MAX && y == V_MAX;
endmodule
